// File: rtl/systolic_drain_if.sv
// Row stream from the systolic drain to the result writeback path.
// The master presents one captured C row per transfer; the slave accepts it with out_ready.
interface systolic_drain_if #(
    parameter int DIM    = 8,
    parameter int BITS_C = 16
);
    localparam int ROW_W = $clog2(DIM);

    logic                         out_valid;
    logic                         out_ready;
    logic [DIM-1:0][BITS_C-1:0]   out_data;
    logic [ROW_W-1:0]             out_row;
    logic                         out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic_drain.sv
// Systolic array result reader: walks the C rows one at a time, captures each
// selected row into an output register and streams it over a valid/ready link.
// Optionally zeroes each row in the array as it is read (clear-on-read).
// The array compute enable is held off for the whole drain.
module systolic_drain #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       clear_en,
    output logic                       busy,
    output logic                       done,
    output logic                       arr_en_hold,
    output logic [$clog2(DIM)-1:0]     crow,
    input  logic [DIM-1:0][BITS_C-1:0] arr_cout,
    output logic                       wren,
    output logic [DIM-1:0][BITS_C-1:0] cin,
    systolic_drain_if.master           out_if
);

    localparam int               ROW_W    = $clog2(DIM);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEL  = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [ROW_W-1:0]           crow_q, crow_d;
    logic                       clear_q, clear_d;
    logic                       out_valid_q, out_valid_d;
    logic [DIM-1:0][BITS_C-1:0] out_data_q, out_data_d;
    logic [ROW_W-1:0]           out_row_q, out_row_d;
    logic                       out_last_q, out_last_d;

    logic handshake;
    logic capture;
    logic row_is_last;

    assign handshake   = out_valid_q & out_if.out_ready;
    assign capture     = (state_q == S_SEL);
    assign row_is_last = (out_row_q == LAST_ROW);

    // State register plus all datapath flops; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            crow_q      <= '0;
            clear_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crow_q      <= crow_d;
            clear_q     <= clear_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state logic: SEL is a single settle/capture cycle, SEND waits for the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                if (handshake) begin
                    state_d = row_is_last ? S_DONE : S_SEL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy        = (state_q != S_IDLE);
        arr_en_hold = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        // The array registers this write at the same edge that captures arr_cout,
        // so the streamed row is always the pre-clear value.
        wren        = (state_q == S_SEL) & clear_q;
    end

    // Row pointer, clear flag and output-register control.
    always_comb begin
        crow_d      = crow_q;
        clear_d     = clear_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    crow_d  = '0;
                    clear_d = clear_en;
                end
            end
            S_SEL: begin
                out_valid_d = 1'b1;
                out_row_d   = crow_q;
                out_last_d  = (crow_q == LAST_ROW);
            end
            S_SEND: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    // The pointer stops at the last row rather than wrapping.
                    if (!row_is_last) begin
                        crow_d = crow_q + ROW_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Per-lane capture of the selected row; held otherwise so the beat stays stable under stall.
    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
            assign out_data_d[gi] = capture ? arr_cout[gi] : out_data_q[gi];
            assign cin[gi]        = '0;
        end
    endgenerate

    assign crow             = crow_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_row   = out_row_q;
    assign out_if.out_last  = out_last_q;

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
Result reader for the systolic MAC array: after a matrix multiply completes, it walks the array's C rows one at a time and streams each row out over a valid/ready interface. It drives the array's row select and, optionally, its row write port, so a row can be cleared to zero as it is read. It sits between the array and the result writeback path, and holds the array's compute enable low while draining.

Parameters:
BITS_C, 16, width of each signed accumulator element
DIM, 8, array dimension (rows and columns); power of two, >= 2

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin drain; accepted only in IDLE
clear_en  input  1  sampled with accepted start; 1 = zero each row after reading it
busy  output  1  drain in progress (state != IDLE)
done  output  1  one-cycle pulse after last row handshake
arr_en_hold  output  1  equals busy; array compute enable is gated low while set
crow  output  $clog2(DIM)  row select to array
arr_cout  input  DIM x BITS_C signed  selected row from array (combinational on crow)
wren  output  1  row write strobe to array
cin  output  DIM x BITS_C signed  row write data; constant zero
out_valid  output  1  out_data/out_row/out_last valid
out_ready  input  1  downstream accepts
out_data  output  DIM x BITS_C signed  captured row
out_row  output  $clog2(DIM)  index of captured row
out_last  output  1  out_row == DIM-1

Behaviour:
- Clock is clk; reset is synchronous, active-high (rst). All state updates on the rising edge of clk.
- Reset values: state=IDLE, crow=0, wren=0, out_valid=0, out_data=0, out_row=0, out_last=0, done=0, busy=0, latched clear flag=0. cin is always 0.
- FSM states: IDLE, SEL, SEND, DONE.
- IDLE: if start=1, latch clear_en, set crow=0, go to SEL. Otherwise hold.
- SEL (one cycle; crow stable and arr_cout settled):
  - wren = latched clear flag (combinational from state).
  - At the edge: out_data <= arr_cout, out_row <= crow, out_last <= (crow==DIM-1), out_valid <= 1, go to SEND.
  - The array write is registered at the same edge, so the captured data is the pre-clear value.
- SEND: out_valid=1. out_data, out_row and out_last are held stable while out_valid=1 and out_ready=0 (no mid-transfer change).
  - On handshake (out_valid & out_ready): out_valid <= 0.
    - If out_row == DIM-1, go to DONE.
    - Else crow <= crow+1 and go to SEL.
- DONE (one cycle): done=1, then go to IDLE. busy falls on the next cycle.
- Throughput: at most one row per 2 cycles.
- Latency with out_ready held high and start accepted at edge E0:
  - row k: SEL in cycle 2k+1, SEND in cycle 2k+2.
  - DIM=8: last handshake in cycle 16, done in cycle 17, busy=0 from cycle 18.
- start while busy is ignored; clear_en is not re-sampled.
- wren never asserts outside SEL and never more than once per row.
- crow does not wrap: the drain terminates at DIM-1.
- rst mid-drain: all outputs take reset values on the next edge. No further wren is issued, no done pulse, and the partially sent frame is abandoned.
- out_ready high while out_valid=0 has no effect.

Test Plan:
- Basic drain, DIM=8: load array rows with C[r][c] = r*16+c, start with clear_en=0, out_ready=1 -> 8 beats, out_row 0..7, out_data matches, out_last only on row 7, done in cycle 17, wren never high, array contents unchanged.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> out_data/out_row stable during each stall, no row lost or duplicated, all 8 rows delivered in order, done only after row 7 handshake.
- Clear-on-read: clear_en=1, C[r][c] = -(r+1) -> streamed values are -(r+1); exactly 8 wren pulses, one per row at crow=r; a re-drain afterwards returns all zeros.
- start while busy: pulse start at cycles 5 and 10 with clear_en=1 -> ignored, still exactly 8 beats, wren never asserted (clear flag from first start =0).
- Reset mid-drain: assert rst during SEND of row 3 with out_ready=0 -> next cycle out_valid=0, busy=0, crow=0, no done pulse; a new start then drains rows 0..7 correctly.
- DIM=4, BITS_C=16: elements 0x7FFF/0x8000 -> 4 beats, sign preserved, out_last on row 3, done in cycle 9.
